// File: rtl/mipi_tx_arbiter.sv
// mipi_tx_arbiter: round-robin packet scheduler in front of the MIPI HS serializer.
// Grants one byte-stream source at a time, runs the phy_hs_req/phy_re handshake,
// streams exactly the granted byte count, then holds off for a minimum gap.
module mipi_tx_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int LEN_W      = 16,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                     clk_hs,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_SRC-1:0]       src_req,
    input  logic [NUM_SRC*LEN_W-1:0] src_len,
    input  logic [NUM_SRC*8-1:0]     src_data,
    output logic [NUM_SRC-1:0]       src_rd,
    output logic [NUM_SRC-1:0]       src_done,
    output logic                     src_err,
    output logic                     phy_hs_req,
    input  logic                     phy_re,
    output logic [7:0]               phy_data,
    output logic                     busy,
    output logic [2:0]               grant
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_SOT   = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    // One counter serves both the REQ timeout and the inter-burst gap.
    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    logic [2:0]         r_state;
    logic [2:0]         r_grant;
    logic [LEN_W-1:0]   r_remaining;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_hs_req;
    logic [NUM_SRC-1:0] r_src_done;
    logic               r_src_err;

    logic [LEN_W-1:0]   w_len_arr [0:7];
    logic [7:0]         w_data_arr [0:7];
    logic [7:0]         w_req_eff;
    logic [NUM_SRC-1:0] w_grant_sel;
    logic [NUM_SRC-1:0] w_pick_sel;
    logic               w_found;
    logic [2:0]         w_pick;
    logic [3:0]         w_scan_idx;
    logic               w_consume;

    assign w_consume = (r_state == ST_SEND) && phy_re && r_hs_req;

    // Unpack the flat per-source buses into fixed 8-entry tables addressed by a 3-bit id.
    // A source whose done pulse is showing may still hold src_req this cycle, so it is
    // masked out to avoid re-granting a packet that just finished.
    for (genvar g = 0; g < 8; g++) begin : g_src
        if (g < NUM_SRC) begin : g_used
            assign w_len_arr[g]   = src_len[g*LEN_W +: LEN_W];
            assign w_data_arr[g]  = src_data[g*8 +: 8];
            assign w_req_eff[g]   = src_req[g] & ~r_src_done[g];
            assign w_grant_sel[g] = (r_grant == 3'(g));
            assign w_pick_sel[g]  = (w_pick == 3'(g));
            assign src_rd[g]      = w_consume & w_grant_sel[g];
        end else begin : g_unused
            assign w_len_arr[g]  = '0;
            assign w_data_arr[g] = '0;
            assign w_req_eff[g]  = 1'b0;
        end
    end

    // Round-robin pick: first pending source scanning from grant+1, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
        w_found    = 1'b0;
        w_pick     = r_grant;
        w_scan_idx = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            w_scan_idx = {1'b0, r_grant} + 4'(i);
            if (w_scan_idx >= 4'(NUM_SRC)) begin
                w_scan_idx = w_scan_idx - 4'(NUM_SRC);
            end
            if (!w_found && w_req_eff[w_scan_idx[2:0]]) begin
                w_found = 1'b1;
                w_pick  = w_scan_idx[2:0];
            end
        end
    end

    // Packet sequencer: grant, PHY handshake, byte streaming, drain and gap.
    always_ff @(posedge clk_hs or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= 3'(NUM_SRC - 1);
            r_remaining <= '0;
            r_cnt       <= '0;
            r_hs_req    <= 1'b0;
            r_src_done  <= '0;
            r_src_err   <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
            r_src_done <= '0;
            r_src_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable && w_found) begin
                        r_grant     <= w_pick;
                        r_remaining <= w_len_arr[w_pick];
                        r_cnt       <= '0;
                        if (w_len_arr[w_pick] == '0) begin
                            // Empty packet: report completion without touching the PHY.
                            r_src_done <= w_pick_sel;
                        end else begin
                            r_hs_req <= 1'b1;
                            r_state  <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (phy_re) begin
                        r_state <= ST_SOT;
                    end else if (r_cnt == TMO_LAST) begin
                        r_hs_req   <= 1'b0;
                        r_src_done <= w_grant_sel;
                        r_src_err  <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_SOT: begin
                    // Start-code cycle: no byte consumed.
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (!phy_re) begin
                        r_hs_req   <= 1'b0;
                        r_src_done <= w_grant_sel;
                        r_src_err  <= 1'b1;
                        r_state    <= ST_DRAIN;
                    end else begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (r_remaining == LEN_W'(1)) begin
                            r_hs_req   <= 1'b0;
                            r_src_done <= w_grant_sel;
                            r_state    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!phy_re) begin
                        r_cnt   <= '0;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_hs_req <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign phy_data   = w_data_arr[r_grant];
    assign phy_hs_req = r_hs_req;
    assign src_done   = r_src_done;
    assign src_err    = r_src_err;
    assign busy       = (r_state != ST_IDLE);
    assign grant      = r_grant;

endmodule

// File: tb/tb_mipi_tx_arbiter.sv
// tb_mipi_tx_arbiter: directed bench for mipi_tx_arbiter with a small PHY and source model.
module tb_mipi_tx_arbiter;

    localparam int NUM_SRC    = 2;
    localparam int LEN_W      = 16;
    localparam int GAP_CYCLES = 16;
    localparam int TIMEOUT    = 1024;

    logic        clk_hs  = 1'b0;
    logic        reset   = 1'b1;
    logic        enable  = 1'b0;
    logic [1:0]  src_req = '0;
    logic [31:0] src_len = '0;
    logic [15:0] src_data;
    logic [1:0]  src_rd;
    logic [1:0]  src_done;
    logic        src_err;
    logic        phy_hs_req;
    logic        phy_re  = 1'b0;
    logic [7:0]  phy_data;
    logic        busy;
    logic [2:0]  grant;

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int phy_mode = 0;   // 0: raise re 5 cycles after hs_req, 1: never raise re
    int re_wait  = 0;
    int ptr0     = 0;
    int ptr1     = 0;
    logic [1:0] rd_seen = '0;

    mipi_tx_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .LEN_W      (LEN_W),
        .GAP_CYCLES (GAP_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_hs     (clk_hs),
        .reset      (reset),
        .enable     (enable),
        .src_req    (src_req),
        .src_len    (src_len),
        .src_data   (src_data),
        .src_rd     (src_rd),
        .src_done   (src_done),
        .src_err    (src_err),
        .phy_hs_req (phy_hs_req),
        .phy_re     (phy_re),
        .phy_data   (phy_data),
        .busy       (busy),
        .grant      (grant)
    );

    always #5 clk_hs = ~clk_hs;

    // Source 0 byte k = 0x11*(k+1); source 1 byte k = 0xA0+k (first-word-fall-through).
    assign src_data = {8'hA0 + 8'(ptr1), 8'((ptr0 + 1) * 17)};

    // src_rd is stable from just after a rising edge until the next one; capture it mid-cycle.
    always @(negedge clk_hs) rd_seen = src_rd;

    // PHY and source pointer model, updated just after each rising edge.
    always @(posedge clk_hs or posedge reset) begin
        if (reset) begin
            phy_re  = 1'b0;
            re_wait = 0;
            ptr0    = 0;
            ptr1    = 0;
        end else begin
            #1;
            if (rd_seen[0]) ptr0++;
            if (rd_seen[1]) ptr1++;
            if (phy_mode == 0 && phy_hs_req) begin
                if (!phy_re) begin
                    if (re_wait == 5) phy_re = 1'b1;
                    else re_wait++;
                end
            end else begin
                phy_re  = 1'b0;
                re_wait = 0;
            end
        end
    end

    task automatic tick;
        @(negedge clk_hs);
        cyc++;
    endtask

    task automatic do_reset;
        reset    = 1'b1;
        src_req  = '0;
        src_len  = '0;
        enable   = 1'b1;
        phy_mode = 0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        tick;
        tick;
        checks++; if (phy_hs_req !== 1'b0) begin errors++; $display("FAIL rst_hs_req: got %b want 0", phy_hs_req); end
        checks++; if (src_rd !== 2'b00) begin errors++; $display("FAIL rst_src_rd: got %b want 00", src_rd); end
        checks++; if (src_done !== 2'b00) begin errors++; $display("FAIL rst_src_done: got %b want 00", src_done); end
        checks++; if (src_err !== 1'b0) begin errors++; $display("FAIL rst_src_err: got %b want 0", src_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (grant !== 3'd1) begin errors++; $display("FAIL rst_grant: got %0d want 1", grant); end
        checks++; if (phy_data !== 8'hA0) begin errors++; $display("FAIL rst_phy_data: got %h want a0", phy_data); end
    endtask

    task automatic test_single_packet;
        logic [7:0] exp_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset;
        src_len = {16'd0, 16'd4};
        src_req = 2'b01;
        tick;  // grant edge seen
        checks++; if (phy_hs_req !== 1'b1) begin errors++; $display("FAIL single_hs_rise: got %b want 1", phy_hs_req); end
        checks++; if (grant !== 3'd0) begin errors++; $display("FAIL single_grant: got %0d want 0", grant); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        repeat (6) tick;  // start-code cycle
        checks++; if (src_rd !== 2'b00) begin errors++; $display("FAIL single_sot_rd: got %b want 00", src_rd); end
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++; if (src_rd !== 2'b01) begin errors++; $display("FAIL single_rd%0d: got %b want 01", k, src_rd); end
            checks++; if (phy_data !== exp_bytes[k]) begin errors++; $display("FAIL single_byte%0d: got %h want %h", k, phy_data, exp_bytes[k]); end
        end
        checks++; if (phy_hs_req !== 1'b1) begin errors++; $display("FAIL single_hs_hold: got %b want 1", phy_hs_req); end
        tick;  // after the last-byte edge
        checks++; if (phy_hs_req !== 1'b0) begin errors++; $display("FAIL single_hs_fall: got %b want 0", phy_hs_req); end
        checks++; if (src_done !== 2'b01) begin errors++; $display("FAIL single_done: got %b want 01", src_done); end
        checks++; if (src_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", src_err); end
        src_req = 2'b00;
        tick;
        checks++; if (src_done !== 2'b00) begin errors++; $display("FAIL single_done_width: got %b want 00", src_done); end
        repeat (15) tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_gap_busy: got %b want 1", busy); end
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        logic prev_hs;
        logic prev_re;
        int   last_rise;
        int   last_fall;
        int   p;
        do_reset;
        src_len   = {16'd2, 16'd2};
        src_req   = 2'b11;
        prev_hs   = 1'b0;
        prev_re   = 1'b0;
        last_rise = 0;
        last_fall = 0;
        p         = 0;
        for (int c = 0; c < 200 && p < 4; c++) begin
            tick;
            if (prev_re && !phy_re) last_fall = cyc;
            if (!prev_hs && phy_hs_req) begin
                checks++; if (grant !== 3'(p % 2)) begin errors++; $display("FAIL rr_grant%0d: got %0d want %0d", p, grant, p % 2); end
                if (p > 0) begin
                    checks++; if (cyc - last_fall < GAP_CYCLES + 1) begin errors++; $display("FAIL rr_gap%0d: got %0d want >= %0d", p, cyc - last_fall, GAP_CYCLES + 1); end
                    checks++; if (cyc - last_rise !== 27) begin errors++; $display("FAIL rr_period%0d: got %0d want 27", p, cyc - last_rise); end
                end
                last_rise = cyc;
                p++;
            end
            prev_hs = phy_hs_req;
            prev_re = phy_re;
        end
        checks++; if (p !== 4) begin errors++; $display("FAIL rr_count: got %0d want 4 packets", p); end
    endtask

    task automatic test_zero_len;
        do_reset;
        src_len = {16'd3, 16'd0};
        src_req = 2'b11;
        tick;
        checks++; if (src_done !== 2'b01) begin errors++; $display("FAIL zero_done: got %b want 01", src_done); end
        checks++; if (src_err !== 1'b0) begin errors++; $display("FAIL zero_err: got %b want 0", src_err); end
        checks++; if (phy_hs_req !== 1'b0) begin errors++; $display("FAIL zero_hs_req: got %b want 0", phy_hs_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
        checks++; if (grant !== 3'd0) begin errors++; $display("FAIL zero_grant: got %0d want 0", grant); end
        src_req = 2'b10;
        tick;
        checks++; if (grant !== 3'd1) begin errors++; $display("FAIL zero_next_grant: got %0d want 1", grant); end
        checks++; if (phy_hs_req !== 1'b1) begin errors++; $display("FAIL zero_next_hs: got %b want 1", phy_hs_req); end
        checks++; if (src_done !== 2'b00) begin errors++; $display("FAIL zero_done_width: got %b want 00", src_done); end
    endtask

    task automatic test_timeout;
        do_reset;
        phy_mode = 1;
        src_len  = {16'd0, 16'd5};
        src_req  = 2'b01;
        tick;
        checks++; if (phy_hs_req !== 1'b1) begin errors++; $display("FAIL tmo_hs_rise: got %b want 1", phy_hs_req); end
        repeat (1023) tick;
        checks++; if (phy_hs_req !== 1'b1) begin errors++; $display("FAIL tmo_hs_hold: got %b want 1", phy_hs_req); end
        checks++; if (src_done !== 2'b00) begin errors++; $display("FAIL tmo_early_done: got %b want 00", src_done); end
        tick;
        checks++; if (phy_hs_req !== 1'b0) begin errors++; $display("FAIL tmo_hs_fall: got %b want 0", phy_hs_req); end
        checks++; if (src_done !== 2'b01) begin errors++; $display("FAIL tmo_done: got %b want 01", src_done); end
        checks++; if (src_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", src_err); end
        src_req = 2'b00;
        repeat (15) tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_gap_busy: got %b want 1", busy); end
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_packet;
        do_reset;
        src_len = {16'd2, 16'd100};
        src_req = 2'b01;
        repeat (20) tick;
        checks++; if (phy_hs_req !== 1'b1) begin errors++; $display("FAIL rmid_hs_before: got %b want 1", phy_hs_req); end
        checks++; if (src_rd !== 2'b01) begin errors++; $display("FAIL rmid_rd_before: got %b want 01", src_rd); end
        src_req = 2'b11;
        reset   = 1'b1;
        #1;
        checks++; if (phy_hs_req !== 1'b0) begin errors++; $display("FAIL rmid_hs: got %b want 0", phy_hs_req); end
        checks++; if (src_rd !== 2'b00) begin errors++; $display("FAIL rmid_rd: got %b want 00", src_rd); end
        checks++; if (src_done !== 2'b00) begin errors++; $display("FAIL rmid_done: got %b want 00", src_done); end
        checks++; if (src_err !== 1'b0) begin errors++; $display("FAIL rmid_err: got %b want 0", src_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
        checks++; if (grant !== 3'd1) begin errors++; $display("FAIL rmid_grant: got %0d want 1", grant); end
        checks++; if (phy_data !== 8'hA0) begin errors++; $display("FAIL rmid_phy_data: got %h want a0", phy_data); end
        tick;
        src_len = {16'd2, 16'd2};
        reset   = 1'b0;
        tick;
        checks++; if (grant !== 3'd0) begin errors++; $display("FAIL rmid_regrant: got %0d want 0", grant); end
        checks++; if (phy_hs_req !== 1'b1) begin errors++; $display("FAIL rmid_rehs: got %b want 1", phy_hs_req); end
    endtask

    task automatic test_enable;
        do_reset;
        src_len = {16'd3, 16'd3};
        src_req = 2'b01;
        tick;
        checks++; if (grant !== 3'd0) begin errors++; $display("FAIL en_grant0: got %0d want 0", grant); end
        tick;
        tick;
        enable  = 1'b0;
        src_req = 2'b11;
        repeat (7) tick;
        checks++; if (phy_hs_req !== 1'b1) begin errors++; $display("FAIL en_hs_hold: got %b want 1", phy_hs_req); end
        tick;
        checks++; if (src_done !== 2'b01) begin errors++; $display("FAIL en_done: got %b want 01", src_done); end
        checks++; if (src_err !== 1'b0) begin errors++; $display("FAIL en_err: got %b want 0", src_err); end
        checks++; if (phy_hs_req !== 1'b0) begin errors++; $display("FAIL en_hs_fall: got %b want 0", phy_hs_req); end
        src_req = 2'b10;
        repeat (16) tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL en_gap_busy: got %b want 1", busy); end
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_idle: got %b want 0", busy); end
        repeat (12) tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_hold_busy: got %b want 0", busy); end
        checks++; if (phy_hs_req !== 1'b0) begin errors++; $display("FAIL en_hold_hs: got %b want 0", phy_hs_req); end
        checks++; if (grant !== 3'd0) begin errors++; $display("FAIL en_hold_grant: got %0d want 0", grant); end
        enable = 1'b1;
        tick;
        checks++; if (grant !== 3'd1) begin errors++; $display("FAIL en_grant1: got %0d want 1", grant); end
        checks++; if (phy_hs_req !== 1'b1) begin errors++; $display("FAIL en_hs_rise: got %b want 1", phy_hs_req); end
    endtask

    initial begin
        test_reset;
        test_single_packet;
        test_back_to_back;
        test_zero_len;
        test_timeout;
        test_reset_mid_packet;
        test_enable;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the run stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached after %0d cycles", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
